// File: rtl/minmax_frame_scanner_pkg.sv
// Shared definitions for the min/max frame scanner.
//   state_t  : frame FSM states
//   MODE_MIN : mode value selecting the minimum search
//   MODE_MAX : mode value selecting the maximum search
package minmax_frame_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/minmax_frame_scanner_lane_cmp_tree.sv
// Combinational reduction of LANES samples to the single best one.
//   data  : LANES packed samples, lane k at [k*WIDTH +: WIDTH]
//   mode  : MODE_MIN or MODE_MAX
//   value : winning sample
//   lane  : lane index of the winner; ties go to the lowest lane
module lane_cmp_tree
    import minmax_frame_scanner_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned SIGNED = 0,
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*WIDTH-1:0] data,
    input  logic                   mode,
    output logic [WIDTH-1:0]       value,
    output logic [LANE_W-1:0]      lane
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic m);
        logic [WIDTH-1:0] ka;
        logic [WIDTH-1:0] kb;
        ka = a ^ FLIP;
        kb = b ^ FLIP;
        // Strict compare: an equal later lane never displaces an earlier one.
        better = (m == MODE_MAX) ? (ka > kb) : (ka < kb);
    endfunction

    always_comb begin
        value = data[0 +: WIDTH];
        lane  = '0;
        for (int unsigned k = 1; k < LANES; k++) begin
            if (better(data[k*WIDTH +: WIDTH], value, mode)) begin
                value = data[k*WIDTH +: WIDTH];
                lane  = LANE_W'(k);
            end
        end
    end

endmodule

// File: rtl/minmax_frame_scanner.sv
// Streaming min/max scanner: reduces each frame of multi-lane beats to the
// winning sample, its index (beat*LANES + lane) and the frame length.
//   clk, resetn          : clock, asynchronous active-low reset
//   mode                 : 0 = minimum, 1 = maximum; latched on the first beat
//   in_valid/in_ready    : input beat handshake
//   in_data, in_last     : LANES samples per beat, end-of-frame marker
//   out_valid/out_ready  : result handshake; result held until consumed
//   out_value, out_index : winning sample and its (saturated) index
//   out_beats, out_ovf   : saturated beat count, index range exceeded
module minmax_frame_scanner
    import minmax_frame_scanner_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_value,
    output logic [IDX_W-1:0]       out_index,
    output logic [IDX_W-1:0]       out_beats,
    output logic                   out_ovf
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    // Wide enough for (2**IDX_W-1)*LANES + LANES-1 without wrapping.
    localparam int unsigned WIDE_W = IDX_W + LANE_W;
    localparam logic [WIDE_W-1:0] MAX_IDX = WIDE_W'({IDX_W{1'b1}});

    state_t state_q, state_d;

    logic               accept;
    logic               first;
    logic               mode_q;
    logic               mode_eff;
    logic [WIDTH-1:0]   beat_value;
    logic [LANE_W-1:0]  beat_lane;
    logic [IDX_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   beat_num;
    logic [WIDE_W-1:0]  beat_base;
    logic [WIDE_W-1:0]  beat_idx;
    logic               beat_ovf;

    logic               s1_valid, s1_last, s1_first, s1_mode, s1_ovf;
    logic [WIDTH-1:0]   s1_value;
    logic [WIDE_W-1:0]  s1_idx;

    logic [WIDTH-1:0]   merge_value;
    logic               merge_lane;
    logic               s2_done;

    logic [WIDTH-1:0]   acc_value;
    logic [IDX_W-1:0]   acc_index;
    logic               acc_ovf;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign first     = (state_q == ST_IDLE);
    assign mode_eff  = first ? mode : mode_q;

    // Stage 1: per-beat lane reduction.
    lane_cmp_tree #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(SIGNED)) u_lanes (
        .data  (in_data),
        .mode  (mode_eff),
        .value (beat_value),
        .lane  (beat_lane)
    );

    assign beat_num  = first ? '0 : beat_cnt;
    assign beat_base = WIDE_W'(beat_num) * WIDE_W'(LANES);
    assign beat_idx  = beat_base + WIDE_W'(beat_lane);
    assign beat_ovf  = (beat_base + WIDE_W'(LANES - 1)) > MAX_IDX;

    // Stage 2: accumulator sits in lane 0 so ties keep the earlier beat.
    lane_cmp_tree #(.WIDTH(WIDTH), .LANES(2), .SIGNED(SIGNED)) u_merge (
        .data  ({s1_value, acc_value}),
        .mode  (s1_mode),
        .value (merge_value),
        .lane  (merge_lane)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = in_last ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (s2_done) state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q    <= MODE_MIN;
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_first  <= 1'b0;
            s1_mode   <= MODE_MIN;
            s1_ovf    <= 1'b0;
            s1_value  <= '0;
            s1_idx    <= '0;
            s2_done   <= 1'b0;
            acc_value <= '0;
            acc_index <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_done  <= s1_valid && s1_last;
            if (accept) begin
                if (first) begin
                    mode_q   <= mode;
                    beat_cnt <= IDX_W'(1);
                end else if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + IDX_W'(1);
                end
                s1_last  <= in_last;
                s1_first <= first;
                s1_mode  <= mode_eff;
                s1_ovf   <= beat_ovf;
                s1_value <= beat_value;
                s1_idx   <= beat_idx;
            end
            if (s1_valid) begin
                acc_value <= s1_first ? s1_value : merge_value;
                if (s1_first || merge_lane) begin
                    acc_index <= (s1_idx > MAX_IDX) ? '1 : s1_idx[IDX_W-1:0];
                end
                acc_ovf <= s1_first ? s1_ovf : (acc_ovf || s1_ovf);
            end
        end
    end

    assign out_value = acc_value;
    assign out_index = acc_index;
    assign out_beats = beat_cnt;
    assign out_ovf   = acc_ovf;

endmodule

// File: doc/minmax_frame_scanner.md
MINMAX_FRAME_SCANNER -- requirements
Module: minmax_frame_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter LANES, default 4, samples per input beat (LANES >= 2).
REQ-003 SHALL have parameter IDX_W, default 16, width of the index and beat-count outputs.
REQ-004 SHALL have parameter SIGNED, default 0; 1 means two's-complement compare, 0 means unsigned compare.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 resetn  in  1  reset, asynchronous and active-low.
REQ-007 mode  in  1  0 = find minimum, 1 = find maximum; sampled on the first beat of a frame.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
REQ-010 in_data  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 in_last  in  1  marks the final beat of a frame.
REQ-012 out_valid  out  1  frame result valid.
REQ-013 out_ready  in  1  result consumed when out_valid and out_ready are both high.
REQ-014 out_value  out  WIDTH  winning sample.
REQ-015 out_index  out  IDX_W  sample index of the winner (beat*LANES + lane).
REQ-016 out_beats  out  IDX_W  number of beats in the frame.
REQ-017 out_ovf  out  1  frame exceeded the index range.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCUM, DRAIN and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN and HOLD.
REQ-019 IDLE->ACCUM SHALL occur on an accepted beat with in_last=0; IDLE->DRAIN and ACCUM->DRAIN SHALL occur on an accepted beat with in_last=1.
REQ-020 Pipeline stage 1 SHALL register the lane-reduction winner (value and lane) of each accepted beat; stage 2 SHALL merge that winner into the frame accumulator.
REQ-021 A result SHALL assert out_valid exactly 2 cycles after the accepted last beat; DRAIN->HOLD SHALL then occur.
REQ-022 HOLD->IDLE SHALL occur on the out handshake; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Ties SHALL resolve to the lowest index, covering both lower lanes within a beat and earlier beats.
REQ-024 mode SHALL be latched on a frame's first accepted beat; changes to mode later in the frame SHALL be ignored.
REQ-025 The beat counter SHALL saturate at 2**IDX_W-1; out_ovf SHALL be set if any sample index exceeds 2**IDX_W-1, and out_index SHALL then saturate at that value.
REQ-026 A single-beat frame SHALL be legal and SHALL produce out_beats=1.
REQ-027 Idle cycles (in_valid=0) within a frame SHALL not alter the accumulator.

Reset
REQ-028 While resetn=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, out_value=0, out_index=0, out_beats=0 and out_ovf=0.
REQ-029 Reset asserted mid-frame or during HOLD SHALL discard all partial or pending results immediately; no out_valid SHALL follow.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the MODE_MIN/MODE_MAX constants.
REQ-031 The lane reduction SHALL be a sub-module lane_cmp_tree (parameters WIDTH, LANES, SIGNED), which is combinational and outputs value and lane index.

Verification (WIDTH=8, LANES=4, IDX_W=16)
REQ-032 Single beat {lane0..3}={11,02,03,04}h, last=1, mode=0 -> out_value=02h, out_index=1, out_beats=1, out_valid 2 cycles after acceptance.
REQ-033 Two beats {11,12,13,14}h then {14,13,12,11}h, mode=1 -> out_value=14h, out_index=3 (first occurrence wins the tie).
REQ-034 SIGNED=1, beat {7F,80,00,FF}h, mode=0 -> out_value=80h, out_index=1; with SIGNED=0 -> out_value=00h, out_index=2.
REQ-035 Result held with out_ready=0 for 5 cycles -> in_ready=0 and out_* stable throughout; handshake -> in_ready=1 on the next cycle.
REQ-036 resetn pulsed low after 2 beats of a 4-beat frame -> no out_valid appears; a following single-beat frame {05,06,07,08}h, mode=0 -> out_value=05h, out_index=0.
REQ-037 Random regression: 1000 random frames of 1-8 beats with random valid/ready gaps; results SHALL match a software model of min/max with lowest-index tie-break.
